alu16_seq: RTL and testbench
============================

// Module: alu16_seq
// PURPOSE
// Multi-cycle sequencer driving the shared 8-bit 6502 ALU to run 8- or 16-bit ops.
// Accepts one command, issues one ALU byte-step per cycle and chains carry between bytes.
// Returns the result with merged C/Z/N/V flags.
// Sits between the CPU decode/control logic and the ALU instance, which it owns exclusively.
// PARAMETERS
// WIDE_EN   1  1: wide=1 requests run two byte-steps; 0: wide ignored, always 8-bit
// PORTS
// clk        in   1   system clock
// reset_n    in   1   synchronous reset, active low
// rdy        in   1   global CPU ready; 0 freezes sequencer and ALU
// start      in   1   command strobe; accepted only when busy=0
// cmd        in   4   0 ADD,1 SUB,2 ORA,3 AND,4 EOR,5 ASL,6 ROL,7 LSR,8 ROR, else pass A
// wide       in   1   1 = 16-bit operation
// a          in   16  operand A (low byte used when 8-bit)
// b          in   16  operand B (ignored for shifts)
// ci         in   1   carry in (ADD/SUB/ROL/ROR)
// bcd        in   1   decimal carry mode, ADD/SUB only
// busy       out  1   command in progress
// done       out  1   one-cycle pulse: result/flags valid
// result     out  16  result, held until next done (high byte 0 when 8-bit)
// co,z,n,v   out  1   flags, held with result
// alu_op     out  5   ALU op code
// alu_right  out  1   ALU right-shift select
// alu_ai     out  8   ALU A byte
// alu_bi     out  8   ALU B byte
// alu_ci     out  1   ALU carry in
// alu_bcd    out  1   ALU BCD mode
// alu_rdy    out  1   ALU register enable
// alu_out    in   8   ALU registered result
// alu_co/alu_z/alu_n/alu_v  in  1  ALU flags, valid the cycle after a step
// BEHAVIOUR
// States: IDLE -> S0 -> (S1 if wide) -> FIN -> IDLE. busy = (state != IDLE).
// Accept at edge with state==IDLE & start & rdy: latch a,b,cmd,ci,bcd,wide&WIDE_EN; go S0.
// Ops: ADD 00100; SUB 01100; ORA 11000; AND 11001; EOR 11010.
// Ops: ASL/ROL 10100; LSR/ROR 11100 with right=1; pass 11100.
// Carry in: ASL/LSR ci=0; ROL/ROR/ADD/SUB use latched ci; logic ops don't care.
// Byte order: low then high, except LSR/ROR, which run high then low.
// S0 drives first byte; S1 drives second byte, alu_ci = alu_co of first step.
// S1 captures first-step alu_out, alu_z, alu_n.
// alu_rdy = rdy & (state==S0|S1). IDLE/FIN: alu_rdy=0.
// alu_bcd = latched bcd & cmd in {ADD,SUB}.
// FIN edge registers result and flags; done=1 in following cycle (state IDLE).
// Latency from accept edge: 2 edges (8-bit), 3 edges (16-bit) to done.
// Flags: z = AND of step Z flags; co = final alu_co, except logic/pass ops, which keep latched ci.
// Flags: n = high-byte step N; v = final alu_v for ADD/SUB, else 0.
// Arithmetic: BCD results are the ALU's uncorrected output; decimal adjust is done downstream.
// rdy=0: state, latches and outputs hold; done pulse holds until rdy returns.
// start with busy=1: ignored, no queueing.
// Back-to-back: start in the done cycle is accepted.
// Reset: state IDLE; busy/done/co/z/n/v = 0; result = 0.
// Reset mid-op aborts with no done.
// TESTING
// ADD wide, 0x12FF+0x0001 ci0 -> result 0x1300, co0 z0 n0 v0; done 3 edges after accept
// SUB wide, 0x0000-0x0001 ci1 -> 0xFFFF, co0 n1 z0; ADD 8-bit, 0x7F+0x01 -> 0x0080, v1 n1
// LSR wide, 0x0101 -> 0x0080, co1 n0 z0; ROR 8-bit ci1, 0x00 -> 0x0080, co0 n1
// ADD wide bcd1, 0x0999+0x0001 ci0 -> 0x1AAA (uncorrected), co0
// rdy low 2 cycles during S1 -> done exactly 2 cycles late, same result
// start while busy ignored; reset_n low in S1 -> busy0, no done, result 0

Source files
------------

// File: rtl/alu16_seq.sv
// alu16_seq: drives the shared 8-bit ALU through one or two byte-steps to run
// 8/16-bit arithmetic, logic and shift commands, chaining carry between bytes.
module alu16_seq #(
    parameter bit WIDE_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        rdy_i,
    input  logic        start_i,
    input  logic [3:0]  cmd_i,
    input  logic        wide_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        ci_i,
    input  logic        bcd_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] result_o,
    output logic        co_o,
    output logic        z_o,
    output logic        n_o,
    output logic        v_o,
    output logic [4:0]  alu_op_o,
    output logic        alu_right_o,
    output logic [7:0]  alu_ai_o,
    output logic [7:0]  alu_bi_o,
    output logic        alu_ci_o,
    output logic        alu_bcd_o,
    output logic        alu_rdy_o,
    input  logic [7:0]  alu_out_i,
    input  logic        alu_co_i,
    input  logic        alu_z_i,
    input  logic        alu_n_i,
    input  logic        alu_v_i
);

    typedef enum logic [1:0] {StIdle, StS0, StS1, StFin} state_e;

    localparam logic [3:0] CmdAdd = 4'd0;
    localparam logic [3:0] CmdSub = 4'd1;
    localparam logic [3:0] CmdOra = 4'd2;
    localparam logic [3:0] CmdAnd = 4'd3;
    localparam logic [3:0] CmdEor = 4'd4;
    localparam logic [3:0] CmdAsl = 4'd5;
    localparam logic [3:0] CmdRol = 4'd6;
    localparam logic [3:0] CmdLsr = 4'd7;
    localparam logic [3:0] CmdRor = 4'd8;

    state_e      state_q, state_d;
    logic [3:0]  cmd_q;
    logic [15:0] a_q, b_q;
    logic        ci_q, bcd_q, wide_q;
    logic [7:0]  first_out_q;
    logic        first_z_q, first_n_q;
    logic [15:0] result_q, result_d;
    logic        co_q, co_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic        done_q, done_d;

    logic is_arith, is_shift, is_rev, shift_no_ci, uses_b, sel_hi;

    always_comb begin
        is_arith    = (cmd_q == CmdAdd) || (cmd_q == CmdSub);
        is_shift    = (cmd_q >= CmdAsl) && (cmd_q <= CmdRor);
        is_rev      = (cmd_q == CmdLsr) || (cmd_q == CmdRor);
        shift_no_ci = (cmd_q == CmdAsl) || (cmd_q == CmdLsr);
        uses_b      = is_arith || (cmd_q == CmdOra) || (cmd_q == CmdAnd) || (cmd_q == CmdEor);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            cmd_q       <= 4'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            ci_q        <= 1'b0;
            bcd_q       <= 1'b0;
            wide_q      <= 1'b0;
            first_out_q <= 8'h00;
            first_z_q   <= 1'b0;
            first_n_q   <= 1'b0;
            result_q    <= 16'h0000;
            co_q        <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            done_q      <= 1'b0;
        end else if (rdy_i) begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == StIdle && start_i) begin
                cmd_q  <= cmd_i;
                a_q    <= a_i;
                b_q    <= b_i;
                ci_q   <= ci_i;
                bcd_q  <= bcd_i;
                wide_q <= wide_i & WIDE_EN;
            end
            if (state_q == StS1) begin
                first_out_q <= alu_out_i;
                first_z_q   <= alu_z_i;
                first_n_q   <= alu_n_i;
            end
            if (state_q == StFin) begin
                result_q <= result_d;
                co_q     <= co_d;
                z_q      <= z_d;
                n_q      <= n_d;
                v_q      <= v_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = StS0;
            StS0:    state_d = wide_q ? StS1 : StFin;
            StS1:    state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Merge the final step (on the ALU outputs now) with the captured first step.
    always_comb begin
        done_d = (state_q == StFin);
        if (!wide_q) begin
            result_d = {8'h00, alu_out_i};
        end else if (is_rev) begin
            result_d = {first_out_q, alu_out_i};
        end else begin
            result_d = {alu_out_i, first_out_q};
        end
        z_d  = alu_z_i & (wide_q ? first_z_q : 1'b1);
        n_d  = (wide_q && is_rev) ? first_n_q : alu_n_i;
        co_d = (is_arith || is_shift) ? alu_co_i : ci_q;
        v_d  = is_arith & alu_v_i;
    end

    always_comb begin
        busy_o      = (state_q != StIdle);
        alu_rdy_o   = rdy_i && ((state_q == StS0) || (state_q == StS1));
        // Right shifts walk high byte first so the dropped bit feeds the low byte.
        sel_hi      = (state_q == StS1) ? !is_rev : (wide_q && is_rev);
        alu_ai_o    = sel_hi ? a_q[15:8] : a_q[7:0];
        alu_bi_o    = uses_b ? (sel_hi ? b_q[15:8] : b_q[7:0]) : 8'h00;
        alu_ci_o    = (state_q == StS1) ? alu_co_i : (ci_q && !shift_no_ci);
        alu_bcd_o   = bcd_q && is_arith;
        alu_right_o = is_rev;
        case (cmd_q)
            CmdAdd:         alu_op_o = 5'b00100;
            CmdSub:         alu_op_o = 5'b01100;
            CmdOra:         alu_op_o = 5'b11000;
            CmdAnd:         alu_op_o = 5'b11001;
            CmdEor:         alu_op_o = 5'b11010;
            CmdAsl, CmdRol: alu_op_o = 5'b10100;
            default:        alu_op_o = 5'b11100;
        endcase
    end

    assign done_o   = done_q;
    assign result_o = result_q;
    assign co_o     = co_q;
    assign z_o      = z_q;
    assign n_o      = n_q;
    assign v_o      = v_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural 8-bit ALU stand-in, vector table, corner
// sequences and randomized commands against a whole-width arithmetic model.
module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        reset_n, rdy, start, wide, ci, bcd;
    logic [3:0]  cmd;
    logic [15:0] a, b;
    logic        busy, done, co, z, n, v;
    logic [15:0] result;
    logic [4:0]  alu_op;
    logic        alu_right, alu_ci, alu_bcd, alu_rdy;
    logic [7:0]  alu_ai, alu_bi;
    logic [7:0]  alu_out = 8'h00;
    logic        alu_co = 1'b0, alu_n = 1'b0, alu_v = 1'b0;
    logic        alu_z;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu16_seq #(.WIDE_EN(1'b1)) dut (
        .clk_i(clk), .reset_ni(reset_n), .rdy_i(rdy), .start_i(start), .cmd_i(cmd),
        .wide_i(wide), .a_i(a), .b_i(b), .ci_i(ci), .bcd_i(bcd),
        .busy_o(busy), .done_o(done), .result_o(result),
        .co_o(co), .z_o(z), .n_o(n), .v_o(v),
        .alu_op_o(alu_op), .alu_right_o(alu_right), .alu_ai_o(alu_ai), .alu_bi_o(alu_bi),
        .alu_ci_o(alu_ci), .alu_bcd_o(alu_bcd), .alu_rdy_o(alu_rdy),
        .alu_out_i(alu_out), .alu_co_i(alu_co), .alu_z_i(alu_z), .alu_n_i(alu_n),
        .alu_v_i(alu_v)
    );

    // Stand-in for the shared 6502 ALU: one byte-step, result registered when enabled.
    function automatic logic [9:0] alu_step(input logic [4:0] op, input logic right,
                                            input logic [7:0] ai, input logic [7:0] bi,
                                            input logic cin, input logic dec);
        logic [7:0] bx, o;
        logic [4:0] lo, hi;
        logic       c, vv, hc;
        o = ai; c = cin; vv = 1'b0;
        case (op)
            5'b00100, 5'b01100: begin
                bx = (op == 5'b01100) ? ~bi : bi;
                lo = {1'b0, ai[3:0]} + {1'b0, bx[3:0]} + {4'b0, cin};
                hc = lo[4] | (dec & (lo[3:1] >= 3'd5));
                hi = {1'b0, ai[7:4]} + {1'b0, bx[7:4]} + {4'b0, hc};
                c  = hi[4] | (dec & (hi[3:1] >= 3'd5));
                o  = {hi[3:0], lo[3:0]};
                vv = ai[7] ^ bx[7] ^ c ^ o[7];
            end
            5'b11000: o = ai | bi;
            5'b11001: o = ai & bi;
            5'b11010: o = ai ^ bi;
            5'b10100: begin o = {ai[6:0], cin}; c = ai[7]; end
            5'b11100: if (right) begin o = {cin, ai[7:1]}; c = ai[0]; end
            default: ;
        endcase
        return {c, vv, o};
    endfunction

    always_ff @(posedge clk) begin
        if (alu_rdy) begin
            {alu_co, alu_v, alu_out} <= alu_step(alu_op, alu_right, alu_ai, alu_bi, alu_ci,
                                                 alu_bcd);
            alu_n <= alu_step(alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd)[7];
        end
    end
    assign alu_z = (alu_out == 8'h00);

    // Whole-operand reference: {result, co, z, n, v}.
    function automatic logic [19:0] ref_model(input logic [3:0] c, input logic w,
                                              input logic [15:0] ra, input logic [15:0] rb,
                                              input logic rci);
        int unsigned wd = w ? 16 : 8;
        int unsigned mask = w ? 32'hFFFF : 32'hFF;
        int unsigned aa = {16'h0, ra} & mask;
        int unsigned bb = {16'h0, rb} & mask;
        int unsigned bx, s, res;
        logic rco, rv;
        rco = rci; rv = 1'b0; res = aa;
        case (c)
            4'd0, 4'd1: begin
                bx  = (c == 4'd1) ? (~bb & mask) : bb;
                s   = aa + bx + {31'b0, rci};
                res = s & mask;
                rco = s[wd];
                rv  = (aa[wd-1] == bx[wd-1]) && (res[wd-1] != aa[wd-1]);
            end
            4'd2: res = aa | bb;
            4'd3: res = aa & bb;
            4'd4: res = aa ^ bb;
            4'd5: begin res = (aa << 1) & mask; rco = aa[wd-1]; end
            4'd6: begin res = ((aa << 1) | {31'b0, rci}) & mask; rco = aa[wd-1]; end
            4'd7: begin res = aa >> 1; rco = aa[0]; end
            4'd8: begin res = (aa >> 1) | ({31'b0, rci} << (wd - 1)); rco = aa[0]; end
            default: ;
        endcase
        return {res[15:0], rco, (res == 0), res[wd-1], rv};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one command at a negedge and count edges from accept until done.
    task automatic run_cmd(input logic [3:0] c, input logic w, input logic [15:0] ra,
                           input logic [15:0] rb, input logic rci, input logic rbcd,
                           output int lat);
        @(negedge clk);
        cmd = c; wide = w; a = ra; b = rb; ci = rci; bcd = rbcd; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1 lat++;
        end
    endtask

    typedef struct {
        logic [3:0]  c;
        logic        w;
        logic [15:0] va, vb;
        logic        vci, vbcd;
        logic [15:0] res;
        logic [3:0]  flags;  // {co, z, n, v}
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;
        logic [19:0] exp;
        logic saw_done;

        vecs[0]  = '{4'd0,  1'b1, 16'h12FF, 16'h0001, 1'b0, 1'b0, 16'h1300, 4'b0000};
        vecs[1]  = '{4'd1,  1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 4'b0010};
        vecs[2]  = '{4'd0,  1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 4'b0011};
        vecs[3]  = '{4'd7,  1'b1, 16'h0101, 16'h0000, 1'b0, 1'b0, 16'h0080, 4'b1000};
        vecs[4]  = '{4'd8,  1'b0, 16'h5500, 16'h0000, 1'b1, 1'b0, 16'h0080, 4'b0010};
        vecs[5]  = '{4'd0,  1'b1, 16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1AAA, 4'b0000};
        vecs[6]  = '{4'd3,  1'b1, 16'hF0F0, 16'h0FF0, 1'b1, 1'b0, 16'h00F0, 4'b1000};
        vecs[7]  = '{4'd4,  1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'b0100};
        vecs[8]  = '{4'd6,  1'b1, 16'h8000, 16'h1234, 1'b1, 1'b0, 16'h0001, 4'b1000};
        vecs[9]  = '{4'd15, 1'b1, 16'h8001, 16'h0F0F, 1'b1, 1'b0, 16'h8001, 4'b1010};
        vecs[10] = '{4'd2,  1'b0, 16'h1200, 16'h0034, 1'b0, 1'b0, 16'h0034, 4'b0000};
        vecs[11] = '{4'd5,  1'b0, 16'h0080, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b1100};

        reset_n = 1'b0; rdy = 1'b1; start = 1'b0; cmd = 4'd0; wide = 1'b0;
        a = 16'h0; b = 16'h0; ci = 1'b0; bcd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", {26'b0, busy, done, co, z, n, v}, 32'h0);
        check("reset_result", {16'b0, result}, 32'h0);
        reset_n = 1'b1;

        // Consecutive calls land start in each done cycle (back-to-back accept).
        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].c, vecs[i].w, vecs[i].va, vecs[i].vb, vecs[i].vci, vecs[i].vbcd,
                    lat);
            check($sformatf("vec%0d_result", i), {16'b0, result}, {16'b0, vecs[i].res});
            check($sformatf("vec%0d_flags", i), {28'b0, co, z, n, v}, {28'b0, vecs[i].flags});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].w ? 3 : 2);
        end

        // rdy low for two cycles while in S1; done also holds while rdy is low.
        @(negedge clk);
        cmd = 4'd0; wide = 1'b1; a = 16'h12FF; b = 16'h0001; ci = 1'b0; bcd = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1 lat++;
            if (lat == 1) rdy = 1'b0;
            if (lat == 3) rdy = 1'b1;
        end
        check("stall_latency", lat, 5);
        check("stall_result", {16'b0, result}, 32'h1300);
        rdy = 1'b0;
        @(posedge clk); #1;
        check("done_hold_rdy_low", {31'b0, done}, 32'd1);
        rdy = 1'b1;
        @(posedge clk); #1;
        check("done_clears", {31'b0, done}, 32'd0);

        // start while busy is ignored and nothing is queued.
        @(negedge clk);
        cmd = 4'd1; wide = 1'b1; a = 16'h0000; b = 16'h0001; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        cmd = 4'd0; a = 16'h1234; b = 16'h1111; ci = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1 lat++;
        end
        check("busy_ignore_latency", lat, 3);
        check("busy_ignore_result", {16'b0, result}, 32'hFFFF);
        @(posedge clk); #1;
        check("no_queued_op", {31'b0, busy}, 32'd0);

        // Reset during S1 aborts without done.
        @(negedge clk);
        cmd = 4'd0; wide = 1'b1; a = 16'h4321; b = 16'h1111; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_state", {29'b0, busy, done, |result}, 32'd0);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            @(posedge clk); #1 saw_done |= done;
        end
        check("abort_no_done", {31'b0, saw_done}, 32'd0);

        // Randomized commands against the whole-width model.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  rc = 4'($urandom_range(0, 15));
            logic        rw = 1'($urandom);
            logic [15:0] ra = 16'($urandom);
            logic [15:0] rb = 16'($urandom);
            logic        rci = 1'($urandom);
            exp = ref_model(rc, rw, ra, rb, rci);
            run_cmd(rc, rw, ra, rb, rci, 1'b0, lat);
            check($sformatf("rnd%0d_cmd%0d_w%0d", i, rc, rw),
                  {12'b0, result, co, z, n, v}, {12'b0, exp});
            check($sformatf("rnd%0d_latency", i), lat, rw ? 3 : 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
